// File: rtl/reg_file_wb.sv
// Purpose: 32-entry architectural register file with a per-register pending-write scoreboard.
// Latency: reads and busy/full flags are combinational (write-through bypass); state updates on the clock edge.
// Backpressure: none; a full scoreboard drops the issue and raises outFull so decode must stall.
module reg_file_wb #(
    parameter int WIDTH   = 32,
    parameter int MAXPEND = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       inRA1,
    input  logic [4:0]       inRA2,
    output logic [WIDTH-1:0] outRD1,
    output logic [WIDTH-1:0] outRD2,
    output logic             outBusy1,
    output logic             outBusy2,
    input  logic             inWE,
    input  logic [4:0]       inWA,
    input  logic [WIDTH-1:0] inWD,
    input  logic             inIssue,
    input  logic [4:0]       inIssueA,
    output logic             outFull,
    output logic             outUnderflow
);

    localparam logic [1:0] PEND_MAX = 2'(MAXPEND);

    logic [WIDTH-1:0] regs_q [32];
    logic [WIDTH-1:0] regs_d [32];
    logic [1:0]       pend_q [32];
    logic [1:0]       pend_d [32];
    logic             underflow_q;
    logic             underflow_d;

    logic wb_ok;
    logic issue_ok;
    logic same_reg;

    assign wb_ok    = inWE && (inWA != 5'd0);
    assign outFull  = (inIssueA != 5'd0) && (pend_q[inIssueA] == PEND_MAX);
    assign issue_ok = inIssue && (inIssueA != 5'd0) && !outFull;
    assign same_reg = issue_ok && wb_ok && (inIssueA == inWA);

    assign outUnderflow = underflow_q;

    // Read ports: r0 is hard zero, a same-cycle write-back is forwarded ahead of the array.
    always_comb begin
        outRD1 = regs_q[inRA1];
        outRD2 = regs_q[inRA2];
        if (wb_ok && (inWA == inRA1)) outRD1 = inWD;
        if (wb_ok && (inWA == inRA2)) outRD2 = inWD;
        if (inRA1 == 5'd0) outRD1 = '0;
        if (inRA2 == 5'd0) outRD2 = '0;
    end

    // Busy: a single outstanding write that lands this cycle is covered by the bypass.
    always_comb begin
        outBusy1 = (inRA1 != 5'd0) && (pend_q[inRA1] != 2'd0);
        outBusy2 = (inRA2 != 5'd0) && (pend_q[inRA2] != 2'd0);
        if (wb_ok && (inWA == inRA1) && (pend_q[inRA1] == 2'd1)) outBusy1 = 1'b0;
        if (wb_ok && (inWA == inRA2) && (pend_q[inRA2] == 2'd1)) outBusy2 = 1'b0;
    end

    // Next state: data write, reservation count and sticky underflow.
    always_comb begin
        regs_d      = regs_q;
        pend_d      = pend_q;
        underflow_d = underflow_q;
        if (wb_ok) regs_d[inWA] = inWD;
        // Issue and write-back to one register cancel; otherwise each applies on its own entry.
        if (!same_reg) begin
            if (issue_ok) pend_d[inIssueA] = pend_q[inIssueA] + 2'd1;
            if (wb_ok) begin
                if (pend_q[inWA] != 2'd0) pend_d[inWA] = pend_q[inWA] - 2'd1;
                else                      underflow_d  = 1'b1;
            end
        end
    end

    // State registers; reset wins over any same-cycle write or issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q      <= '{default: '0};
            pend_q      <= '{default: '0};
            underflow_q <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            pend_q      <= pend_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_reg_file_wb.sv
// Purpose: randomized + directed check of reg_file_wb against a behavioural model through a scoreboard queue.
// Latency: expectations are produced when inputs are applied and compared on the following falling edge.
// Backpressure: not applicable; every cycle yields one expected output record.
module tb_reg_file_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  inRA1, inRA2, inWA, inIssueA;
    logic [31:0] inWD;
    logic        inWE, inIssue;
    logic [31:0] outRD1, outRD2;
    logic        outBusy1, outBusy2, outFull, outUnderflow;

    always #5 clk = ~clk;

    reg_file_wb #(.WIDTH(32), .MAXPEND(3)) dut (
        .clk(clk), .rst(rst),
        .inRA1(inRA1), .inRA2(inRA2),
        .outRD1(outRD1), .outRD2(outRD2),
        .outBusy1(outBusy1), .outBusy2(outBusy2),
        .inWE(inWE), .inWA(inWA), .inWD(inWD),
        .inIssue(inIssue), .inIssueA(inIssueA),
        .outFull(outFull), .outUnderflow(outUnderflow)
    );

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        b1;
        logic        b2;
        logic        full;
        logic        unf;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: architectural contents, outstanding write count, sticky error.
    logic [31:0] m_mem  [32];
    int          m_pend [32];
    bit          m_unf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compare whatever the DUT presents against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rd1",   outRD1,               e.rd1);
            chk("rd2",   outRD2,               e.rd2);
            chk("busy1", {31'd0, outBusy1},     {31'd0, e.b1});
            chk("busy2", {31'd0, outBusy2},     {31'd0, e.b2});
            chk("full",  {31'd0, outFull},      {31'd0, e.full});
            chk("unf",   {31'd0, outUnderflow}, {31'd0, e.unf});
        end
    end

    function automatic logic [31:0] m_read(input logic [4:0] ra, input bit we,
                                           input logic [4:0] wa, input logic [31:0] wd);
        if (ra == 5'd0) return 32'd0;
        if (we && wa == ra) return wd;
        return m_mem[ra];
    endfunction

    function automatic logic m_busy(input logic [4:0] ra, input bit we, input logic [4:0] wa);
        if (ra == 5'd0 || m_pend[ra] == 0) return 1'b0;
        if (m_pend[ra] == 1 && we && wa == ra) return 1'b0;
        return 1'b1;
    endfunction

    // Apply one cycle of inputs, queue the expected response, then advance the model past the edge.
    task automatic cyc(input bit r, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input bit iss, input logic [4:0] ia, input logic [4:0] ra1, input logic [4:0] ra2);
        exp_t e;
        bit   iss_ok;
        bit   wb;
        rst = r; inWE = we; inWA = wa; inWD = wd; inIssue = iss; inIssueA = ia;
        inRA1 = ra1; inRA2 = ra2;
        e.rd1  = m_read(ra1, we, wa, wd);
        e.rd2  = m_read(ra2, we, wa, wd);
        e.b1   = m_busy(ra1, we, wa);
        e.b2   = m_busy(ra2, we, wa);
        e.full = (ia != 5'd0) && (m_pend[ia] == 3);
        e.unf  = m_unf;
        exp_q.push_back(e);
        if (r) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i]  = 32'd0;
                m_pend[i] = 0;
            end
            m_unf = 0;
        end else begin
            iss_ok = iss && ia != 5'd0 && m_pend[ia] < 3;
            wb     = we && wa != 5'd0;
            if (wb) m_mem[wa] = wd;
            if (!(iss_ok && wb && ia == wa)) begin
                if (iss_ok) m_pend[ia]++;
                if (wb) begin
                    if (m_pend[wa] > 0) m_pend[wa]--;
                    else                m_unf = 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Initial reset: outputs before it are undefined, so nothing is queued.
        rst = 1'b1; inWE = 0; inWA = 0; inWD = 0; inIssue = 0; inIssueA = 0; inRA1 = 0; inRA2 = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = 32'd0;
            m_pend[i] = 0;
        end
        m_unf = 0;

        // Reset state reads.
        cyc(0, 0, 0, 0, 0, 5, 5, 31);
        // Write with same-cycle bypass, then from the array; r0 stays zero.
        cyc(0, 1, 7, 32'hDEADBEEF, 0, 0, 7, 0);
        cyc(0, 0, 0, 0, 0, 0, 7, 7);
        cyc(0, 1, 0, 32'h1234, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 7);
        // Fill r3 to the limit, fourth issue dropped, drain with three write-backs.
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 3, 3, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 3, 32'h300 + i, 0, 3, 3, 3);
        cyc(0, 0, 0, 0, 1, 3, 3, 3);
        cyc(0, 1, 3, 32'h3FF, 0, 3, 0, 3);
        // Simultaneous issue and write-back to r9 with one reservation outstanding.
        cyc(0, 0, 0, 0, 1, 9, 9, 0);
        cyc(0, 1, 9, 32'h99, 1, 9, 0, 0);
        cyc(0, 0, 0, 0, 0, 9, 9, 9);
        // Underflow: write-back to an unreserved r4, flag sticks.
        cyc(0, 1, 4, 32'h44, 0, 4, 0, 0);
        cyc(0, 0, 0, 0, 0, 4, 4, 4);
        cyc(0, 0, 0, 0, 0, 0, 1, 2);
        // Reset mid-operation discards reservations and a same-cycle write.
        cyc(0, 1, 2, 32'h55, 0, 0, 2, 0);
        cyc(0, 0, 0, 0, 1, 2, 2, 0);
        cyc(0, 0, 0, 0, 1, 2, 2, 0);
        cyc(1, 1, 2, 32'h66, 1, 2, 2, 0);
        cyc(0, 0, 0, 0, 0, 2, 2, 2);

        // Random traffic on a narrow address range to force collisions.
        for (int n = 0; n < 3000; n++) begin
            bit          r, we, iss;
            logic [4:0]  wa, ia, ra1, ra2;
            logic [31:0] wd;
            r   = ($urandom_range(0, 199) == 0);
            we  = $urandom_range(0, 1);
            iss = ($urandom_range(0, 2) != 0);
            wa  = ($urandom_range(0, 15) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            ia  = ($urandom_range(0, 15) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            ra1 = ($urandom_range(0, 1) == 0) ? wa : 5'($urandom_range(0, 7));
            ra2 = ($urandom_range(0, 1) == 0) ? ia : 5'($urandom_range(0, 31));
            wd  = $urandom;
            // Issue+write-back to one register at a saturated or empty count is left undefined here.
            if (iss && we && ia == wa && wa != 5'd0 && (m_pend[ia] == 3 || m_pend[ia] == 0))
                iss = 0;
            cyc(r, we, wa, wd, iss, ia, ra1, ra2);
        end

        @(negedge clk);
        chk("drain", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
